// File: rtl/psram_bist_pkg.sv
// Shared definitions for the PSRAM BIST sequencer: FSM encoding, default seed
// and the address-to-pattern function.
package psram_bist_pkg;

  localparam logic [15:0] DEFAULT_SEED = 16'hA5C3;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_INIT = 3'd1;
  localparam logic [2:0] WR_REQ    = 3'd2;
  localparam logic [2:0] WR_WAIT   = 3'd3;
  localparam logic [2:0] RD_REQ    = 3'd4;
  localparam logic [2:0] RD_WAIT   = 3'd5;
  localparam logic [2:0] CHECK     = 3'd6;
  localparam logic [2:0] FIN       = 3'd7;

  // Seeded word rotated left by the low address nibble; doubling the word
  // makes the rotate a plain shift.
  function automatic logic [15:0] pat(input logic [15:0] a, input logic [15:0] seed);
    logic [31:0] dbl;
    dbl = {a ^ seed, a ^ seed} << a[3:0];
    return dbl[31:16];
  endfunction

endpackage

// File: rtl/psram_bist_pattern.sv
// Combinational address-to-test-pattern mapping; only the low 16 address bits
// take part in the pattern.
module psram_bist_pattern
  import psram_bist_pkg::*;
#(
  parameter int          ADDR_W = 22,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       pattern
);

  logic [15:0] addr_lo;

  generate
    if (ADDR_W > 16) begin : g_wide
      logic addr_hi_unused;
      assign addr_lo        = addr[15:0];
      assign addr_hi_unused = ^addr[ADDR_W-1:16];
    end else if (ADDR_W == 16) begin : g_exact
      assign addr_lo = addr;
    end else begin : g_narrow
      assign addr_lo = {{(16-ADDR_W){1'b0}}, addr};
    end
  endgenerate

  assign pattern = pat(addr_lo, SEED);

endmodule

// File: rtl/psram_bist_sequencer.sv
// PSRAM built-in self-test: writes pat(addr) over NUM_WORDS addresses, reads
// them back and counts mismatches, exposing expected/returned words as registers.
module psram_bist_sequencer
  import psram_bist_pkg::*;
#(
  parameter int          ADDR_W    = 22,
  parameter int          NUM_WORDS = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              init_done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [15:0]       cmd_wdata,
  input  logic              cmd_done,
  input  logic [15:0]       rd_data,
  output logic [15:0]       message,
  output logic [15:0]       read,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int                CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  idx_reg;
  logic [15:0]       cur_pat;
  logic              is_last;

  psram_bist_pattern #(
    .ADDR_W (ADDR_W),
    .SEED   (SEED)
  ) u_pattern (
    .addr    (addr_reg),
    .pattern (cur_pat)
  );

  // The word index decides "last word" so the address may wrap freely.
  assign is_last = (idx_reg == LAST_IDX);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      idx_reg   <= '0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      message   <= '0;
      read      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= WAIT_INIT;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            busy      <= 1'b1;
            addr_reg  <= BASE;
            idx_reg   <= '0;
          end
        end
        WAIT_INIT: begin
          if (init_done) state_reg <= WR_REQ;
        end
        // Request states raise cmd_valid with its payload, then hold it all
        // until the controller takes it.
        WR_REQ: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_write <= 1'b1;
            cmd_addr  <= addr_reg;
            cmd_wdata <= cur_pat;
            message   <= cur_pat;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state_reg <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (cmd_done) begin
            if (is_last) begin
              addr_reg  <= BASE;
              idx_reg   <= '0;
              state_reg <= RD_REQ;
            end else begin
              addr_reg  <= addr_reg + ADDR_W'(1);
              idx_reg   <= idx_reg + CNT_W'(1);
              state_reg <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_write <= 1'b0;
            cmd_addr  <= addr_reg;
            cmd_wdata <= '0;
            message   <= cur_pat;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state_reg <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cmd_done) begin
            read      <= rd_data;
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (read != message) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) fail_addr <= addr_reg;
          end
          if (is_last) begin
            state_reg <= FIN;
          end else begin
            addr_reg  <= addr_reg + ADDR_W'(1);
            idx_reg   <= idx_reg + CNT_W'(1);
            state_reg <= RD_REQ;
          end
        end
        FIN: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= (err_count == 16'd0);
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_bist_sequencer.sv
// Bench for psram_bist_sequencer: a PSRAM responder model records accepted
// commands and read-backs; the main sequence checks them against the pattern rule.
module tb_psram_bist_sequencer;

  localparam int          AW      = 22;
  localparam int          NW      = 4;
  localparam int          NW_SAT  = 65537;
  localparam logic [15:0] TB_SEED = 16'hA5C3;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [15:0] wdata;
    logic [15:0] msg;
  } cmd_t;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Main DUT signals
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          init_done = 1'b1;
  logic          cmd_ready = 1'b1;
  logic          cmd_done = 1'b0;
  logic [15:0]   rd_data = 16'h0;
  logic          cmd_valid, cmd_write, busy, done, pass;
  logic [AW-1:0] cmd_addr, fail_addr;
  logic [15:0]   cmd_wdata, message, read, err_count;

  // Saturation DUT signals
  logic          s_start = 1'b0;
  logic          s_cmd_ready = 1'b1;
  logic          s_cmd_done = 1'b0;
  logic [15:0]   s_rd_data = 16'h0;
  logic          s_cmd_valid, s_cmd_write, s_busy, s_done, s_pass;
  logic [AW-1:0] s_cmd_addr, s_fail_addr;
  logic [15:0]   s_cmd_wdata, s_message, s_read, s_err_count;

  psram_bist_sequencer #(
    .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR(0), .SEED(TB_SEED)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_done(cmd_done),
    .rd_data(rd_data), .message(message), .read(read), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .fail_addr(fail_addr)
  );

  psram_bist_sequencer #(
    .ADDR_W(AW), .NUM_WORDS(NW_SAT), .BASE_ADDR(0), .SEED(TB_SEED)
  ) dut_sat (
    .sys_clk(sys_clk), .rst(rst), .start(s_start), .init_done(init_done),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_write(s_cmd_write),
    .cmd_addr(s_cmd_addr), .cmd_wdata(s_cmd_wdata), .cmd_done(s_cmd_done),
    .rd_data(s_rd_data), .message(s_message), .read(s_read), .busy(s_busy),
    .done(s_done), .pass(s_pass), .err_count(s_err_count), .fail_addr(s_fail_addr)
  );

  // Reference pattern: XOR with seed, then move bit i to bit (i+k) mod 16.
  function automatic logic [15:0] ref_pat(input int unsigned a);
    logic [15:0] x, r;
    int unsigned k;
    x = 16'(a % 65536) ^ TB_SEED;
    k = a % 16;
    r = '0;
    for (int i = 0; i < 16; i++) r[(i + k) % 16] = x[i];
    return r;
  endfunction

  // Knobs written by the main sequence, read by the responder
  int          lat = 2;
  bit          rand_ready = 1'b0;
  bit          run_live = 1'b0;
  int          stall_gen = 0;
  logic [15:0] corrupt [NW];

  // Responder-owned state
  cmd_t          acc_q[$];
  logic [15:0]   robs_q[$];
  logic [15:0]   rexp_q[$];
  logic [15:0]   mem [int];
  bit            acc_flag = 1'b0;
  cmd_t          acc_cmd;
  int            countdown = 0;
  bit            pend_rd = 1'b0;
  logic [15:0]   pend = 16'h0;
  bit            chk_read = 1'b0;
  int            stall_seen = 0, stall_left = 0, stall_bad = 0, stall_cycles = 0;
  logic [AW-1:0] snap_addr;
  logic [15:0]   snap_wdata;

  always @(negedge sys_clk) begin
    if (chk_read) begin
      robs_q.push_back(read);
      rexp_q.push_back(pend);
      chk_read = 1'b0;
    end
    cmd_done = 1'b0;
    if (acc_flag) begin
      acc_q.push_back(acc_cmd);
      if (acc_cmd.wr) begin
        mem[int'(acc_cmd.addr)] = acc_cmd.wdata;
        pend_rd = 1'b0;
      end else begin
        pend = mem.exists(int'(acc_cmd.addr)) ? mem[int'(acc_cmd.addr)] : 16'h0000;
        if (int'(acc_cmd.addr) < NW) pend = pend ^ corrupt[int'(acc_cmd.addr)];
        pend_rd = 1'b1;
      end
      countdown = lat;
    end
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        cmd_done = 1'b1;
        if (pend_rd) begin
          rd_data  = pend;
          chk_read = run_live;
        end
      end
    end
    if (stall_gen != stall_seen && cmd_valid === 1'b1) begin
      stall_seen = stall_gen;
      stall_left = 10;
      snap_addr  = cmd_addr;
      snap_wdata = cmd_wdata;
    end
    if (stall_left > 0) begin
      if (cmd_valid !== 1'b1 || cmd_addr !== snap_addr || cmd_wdata !== snap_wdata) stall_bad++;
      stall_cycles++;
      stall_left--;
      cmd_ready = 1'b0;
    end else begin
      cmd_ready = rand_ready ? ($urandom_range(1, 0) != 0) : 1'b1;
    end
    acc_flag = cmd_valid && cmd_ready;
    acc_cmd  = '{wr: cmd_write, addr: cmd_addr, wdata: cmd_wdata, msg: message};
  end

  // Saturation responder: always ready, done one cycle after acceptance, reads 0
  bit s_acc = 1'b0;
  always @(negedge sys_clk) begin
    s_cmd_done = s_acc;
    s_acc      = s_cmd_valid && s_cmd_ready;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int q_base = 0;
  int r_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    q_base   = acc_q.size();
    r_base   = robs_q.size();
    run_live = 1'b1;
    start    = 1'b1;
    @(negedge sys_clk);
    start    = 1'b0;
  endtask

  task automatic finish_run(input string name, input int exp_err, input int exp_fail);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check({name, "_finished_in_time"}, 32'(n < 2000), 32'd1);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pass"}, 32'(pass), 32'(exp_err == 0));
    check({name, "_err_count"}, 32'(err_count), 32'(exp_err));
    check({name, "_fail_addr"}, 32'(fail_addr), 32'(exp_fail));
    check({name, "_n_cmds"}, 32'(acc_q.size() - q_base), 32'(2 * NW));
    for (int k = 0; k < 2 * NW && q_base + k < acc_q.size(); k++) begin
      cmd_t c;
      int   a;
      c = acc_q[q_base + k];
      a = k % NW;
      check($sformatf("%s_cmd%0d_write", name, k), 32'(c.wr), 32'(k < NW));
      check($sformatf("%s_cmd%0d_addr", name, k), 32'(c.addr), 32'(a));
      check($sformatf("%s_cmd%0d_msg", name, k), 32'(c.msg), 32'(ref_pat(a)));
      if (k < NW) check($sformatf("%s_cmd%0d_wdata", name, k), 32'(c.wdata), 32'(ref_pat(a)));
    end
    check({name, "_n_reads"}, 32'(robs_q.size() - r_base), 32'(NW));
    for (int k = r_base; k < robs_q.size(); k++)
      check($sformatf("%s_read%0d", name, k - r_base), 32'(robs_q[k]), 32'(rexp_q[k]));
    run_live = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({name, "_cmd_write"}, 32'(cmd_write), 32'd0);
    check({name, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
    check({name, "_cmd_wdata"}, 32'(cmd_wdata), 32'd0);
    check({name, "_message"}, 32'(message), 32'd0);
    check({name, "_read"}, 32'(read), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_pass"}, 32'(pass), 32'd0);
    check({name, "_err_count"}, 32'(err_count), 32'd0);
    check({name, "_fail_addr"}, 32'(fail_addr), 32'd0);
  endtask

  initial begin
    int n, bad, sc0, sb0, exp_err, exp_fail;
    for (int k = 0; k < NW; k++) corrupt[k] = 16'h0;

    // Reset values
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge sys_clk);

    // Clean run, ready always high, done two cycles after acceptance
    start_run();
    finish_run("clean", 0, 0);
    $display("txn clean: err_count=%h pass=%0d", err_count, pass);

    // Bit 0 of the word read from address 2 flipped
    corrupt[2] = 16'h0001;
    start_run();
    finish_run("corrupt2", 1, 2);
    $display("txn corrupt2: err_count=%h fail_addr=%0h", err_count, fail_addr);
    corrupt[2] = 16'h0000;

    // init_done held low for 50 cycles, dropped again mid-run
    init_done = 1'b0;
    start_run();
    check("init_busy", 32'(busy), 32'd1);
    bad = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (cmd_valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("init_hold_cycles_bad", 32'(bad), 32'd0);
    init_done = 1'b1;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    check("init_first_write_within_2", 32'(n <= 2), 32'd1);
    repeat (3) @(negedge sys_clk);
    init_done = 1'b0;
    finish_run("init", 0, 0);
    init_done = 1'b1;
    $display("txn init: first write %0d cycles after init_done", n);

    // Ready held low for 10 cycles on the first command; start while busy
    sc0 = stall_cycles;
    sb0 = stall_bad;
    stall_gen++;
    start_run();
    repeat (20) @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    finish_run("stall", 0, 0);
    check("stall_cycles", 32'(stall_cycles - sc0), 32'd10);
    check("stall_unstable_cycles", 32'(stall_bad - sb0), 32'd0);
    $display("txn stall: %0d stalled cycles", stall_cycles - sc0);

    // Randomized ready, latency and read corruption
    for (int t = 0; t < 4; t++) begin
      rand_ready = 1'b1;
      lat        = int'($urandom_range(4, 1));
      exp_err    = 0;
      exp_fail   = 0;
      for (int k = 0; k < NW; k++) begin
        corrupt[k] = ($urandom_range(1, 0) != 0) ? 16'($urandom_range(16'hFFFF, 1)) : 16'h0;
        if (corrupt[k] != 16'h0) begin
          if (exp_err == 0) exp_fail = k;
          exp_err++;
        end
      end
      start_run();
      finish_run($sformatf("rand%0d", t), exp_err, exp_fail);
      $display("txn rand%0d: lat=%0d err_count=%h fail_addr=%0h", t, lat, err_count, fail_addr);
    end
    rand_ready = 1'b0;
    for (int k = 0; k < NW; k++) corrupt[k] = 16'h0;

    // Reset while waiting for the read of address 1; its cmd_done lands after reset
    lat = 3;
    start_run();
    n = 0;
    while (acc_q.size() - q_base < NW + 2 && n < 500) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    check("rst_reached_rd_wait", 32'(n < 500), 32'd1);
    run_live = 1'b0;
    rst      = 1'b1;
    @(negedge sys_clk);
    check_all_zero("midrst");
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge sys_clk);
      if (cmd_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst_stays_idle", 32'(bad), 32'd0);
    lat = 2;
    start_run();
    finish_run("rerun", 0, 0);
    $display("txn rerun after reset: err_count=%h", err_count);

    // start coincident with rst: reset wins
    rst   = 1'b1;
    start = 1'b1;
    @(negedge sys_clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_valid", 32'(cmd_valid), 32'd0);
    check("rst_start_done", 32'(done), 32'd0);
    $display("txn start with rst: busy=%0d", busy);

    // 65537 words all read back as zero: the error counter must saturate
    s_start = 1'b1;
    @(negedge sys_clk);
    s_start = 1'b0;
    n = 0;
    while (s_done !== 1'b1 && n < 600000) begin
      @(negedge sys_clk);
      n++;
    end
    check("sat_finished_in_time", 32'(n < 600000), 32'd1);
    check("sat_err_count", 32'(s_err_count), 32'h0000FFFF);
    check("sat_fail_addr", 32'(s_fail_addr), 32'd0);
    check("sat_pass", 32'(s_pass), 32'd0);
    check("sat_busy", 32'(s_busy), 32'd0);
    $display("txn saturate: err_count=%h fail_addr=%0h", s_err_count, s_fail_addr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
